// File: rtl/output_regbank_pkg.sv
// Shared types, address-field positions and helpers for the output register bank.
package output_regbank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_TGL   = 2'b11
  } op_e;

  localparam int unsigned CH_LSB  = 12;
  localparam int unsigned CH_MSB  = 15;
  localparam int unsigned SEL_BIT = 4;
  localparam int unsigned OP_LSB  = 2;

  function automatic logic [31:0] bmask_expand(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/output_regbank_blink_prescaler.sv
// Blink phase generator: phase toggles once every DIV clocks.
module blink_prescaler #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_phase
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt     <= '0;
      o_phase <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt     <= '0;
      o_phase <= ~o_phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/output_regbank.sv
// Memory-mapped output register bank: NUM_CH channels, byte-enabled atomic ops.
// Optional blink engine compiled in with `define OUTPUT_BLINK_EN.
module output_regbank
  import output_regbank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter logic [15:0] BASE_HI   = 16'h1000,
  parameter logic [31:0] RST_VAL   = 32'h0,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wren,
  input  logic                     i_rden,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_data,
  input  logic [3:0]               i_bmask,
  output logic [31:0]              o_rdata,
  output logic                     o_hit,
  output logic [NUM_CH*32-1:0]     o_chan
);

  logic [3:0]  ch;
  logic        sel_blink;
  op_e         op;
  logic        bank_hit;
  logic        ch_ok;
  logic [31:0] mask;
  logic [31:0] wdata;
  logic [31:0] rd_raw;
  logic [31:0] data_r [NUM_CH];
  logic        unused_addr;

  assign ch        = i_addr[CH_MSB:CH_LSB];
  assign sel_blink = i_addr[SEL_BIT];
  assign op        = op_e'(i_addr[OP_LSB+1:OP_LSB]);
  assign bank_hit  = (i_addr[31:16] == BASE_HI);
  assign ch_ok     = (32'(ch) < NUM_CH);
  assign mask      = bmask_expand(i_bmask);
  assign wdata     = i_data & mask;
  assign unused_addr = ^{i_addr[11:5], i_addr[1:0]};

  function automatic logic [31:0] apply_op(input op_e o, input logic [31:0] r,
                                           input logic [31:0] m, input logic [31:0] d);
    case (o)
      OP_WRITE: return (r & ~m) | d;
      OP_SET:   return r | d;
      OP_CLR:   return r & ~d;
      OP_TGL:   return r ^ d;
      default:  return r;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) data_r[k] <= RST_VAL;
    end else if (i_wren && o_hit && !sel_blink) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (32'(ch) == k) data_r[k] <= apply_op(op, data_r[k], mask, wdata);
      end
    end
  end

`ifdef OUTPUT_BLINK_EN
  logic [31:0] blink_r [NUM_CH];
  logic        phase;

  assign o_hit = bank_hit && ch_ok;

  // Blink masks take plain write semantics whatever the op field says.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) blink_r[k] <= '0;
    end else if (i_wren && o_hit && sel_blink) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (32'(ch) == k) blink_r[k] <= (blink_r[k] & ~mask) | wdata;
      end
    end
  end

  blink_prescaler #(.DIV(BLINK_DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_phase (phase)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign o_chan[32*k +: 32] = data_r[k] & ~(blink_r[k] & {32{phase}});
  end

  always_comb begin
    rd_raw = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(ch) == k) rd_raw = sel_blink ? blink_r[k] : data_r[k];
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^BLINK_DIV;
  assign o_hit      = bank_hit && ch_ok && !sel_blink;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign o_chan[32*k +: 32] = data_r[k];
  end

  always_comb begin
    rd_raw = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(ch) == k) rd_raw = data_r[k];
    end
  end
`endif

  // Read data is captured from pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rdata <= '0;
    end else if (i_rden) begin
      o_rdata <= o_hit ? rd_raw : '0;
    end
  end

endmodule

// File: doc/output_regbank.md
# output_regbank

Parametrised memory-mapped output register bank and the next generation of the LED/HEX/LCD output path on the data-memory bus. Provides `NUM_CH` independent 32-bit output channels instead of one shared buffer, each mapped to its own 4 KiB page. Writes support byte enables and atomic set/clear/toggle operations. Reads return registered data, and an optional hardware blink engine is available. The LSU drives it in parallel with data memory; top level slices `o_chan` onto LEDR, LEDG, HEX0-7 and LCD pins.

## Interface
- `NUM_CH`, 8: number of output channels, 1..16.
- `BASE_HI`, 16'h1000: value of `i_addr[31:16]` that selects the bank.
- `RST_VAL`, 32'h0: reset value of every channel register.
- `BLINK_DIV`, 25_000_000: prescaler period in clocks per blink phase, ≥2; used only with blink compiled in.
- `i_clk` in 1: clock; all state on rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_wren` in 1: write strobe, one cycle per access.
- `i_rden` in 1: read strobe.
- `i_addr` in 32: byte address; `[1:0]` ignored.
- `i_data` in 32: write data.
- `i_bmask` in 4: byte enables; bit k covers `i_data[8k+7:8k]`.
- `o_rdata` out 32: registered read data.
- `o_hit` out 1: combinational; the address decodes to a mapped register.
- `o_chan` out NUM_CH*32: channel k on bits `[32k+31:32k]`, effective (post-blink) value.

## Operation
- Decode:
  - bank hit when `i_addr[31:16]==BASE_HI`.
  - `ch=i_addr[15:12]`; the channel is mapped only if `ch<NUM_CH`.
  - `i_addr[4]` selects the blink-mask register (1) or the data register (0).
  - `op=i_addr[3:2]`.
- Data register ops, where `m` = byte-enable-expanded mask and `d=i_data&m`:
  - OP_WRITE 00: `r=(r&~m)|d`.
  - OP_SET 01: `r=r|d`.
  - OP_CLR 10: `r=r&~d`.
  - OP_TGL 11: `r=r^d`.
- Blink-mask register: OP_WRITE semantics for every op value.
- Unmapped channel, or `i_addr[4]=1` with blink compiled out:
  - writes are ignored.
  - `o_hit=0`.
  - a read returns 0.
- Reads: `o_rdata` is the raw data register or blink mask, never the post-blink value. `o_rdata` holds its value when `i_rden=0`.
- Simultaneous `i_wren` and `i_rden` to the same register: the read returns the pre-write value.
- `i_wren` with `i_bmask=0`: no state change.

## Timing
- Reset (async assert, sync release), all values held while `i_reset=0`:
  - all data registers = `RST_VAL`.
  - blink masks = 0.
  - `o_rdata=0`.
  - prescaler = 0.
  - phase = 0.
- Write accepted on edge N: `o_chan` reflects the new value after edge N (zero extra latency; `o_chan` is driven from flops through AND logic only).
- Read issued in cycle N: `o_rdata` is valid after edge N and stays valid until the next read.
- Back-to-back accesses every cycle are supported; there are no stalls and no handshake.
- Blink, when compiled in:
  - prescaler counts 0..`BLINK_DIV-1` and wraps to 0.
  - phase toggles on the edge where the count wraps, i.e. one phase per `BLINK_DIV` clocks.
  - `o_chan[k] = phase ? r[k] & ~blink[k] : r[k]`.
  - a write does not reset the prescaler.
- Reset asserted mid-phase: the counter and phase clear immediately, and the first toggle after release occurs `BLINK_DIV` clocks later.

## Configuration
- `OUTPUT_BLINK_EN`:
  - Defined: per-channel blink-mask registers, prescaler and phase logic are present.
  - Undefined: none of this logic exists, `o_chan` equals the data registers directly, and `BLINK_DIV` is unused.

## Structure
- Package `output_regbank_pkg`:
  - op enum `op_e` {OP_WRITE, OP_SET, OP_CLR, OP_TGL}.
  - address field localparams (CH_LSB=12, CH_MSB=15, SEL_BIT=4, OP_LSB=2).
  - function `bmask_expand(4→32)`.
- Sub-module `blink_prescaler`:
  - parameter `DIV`.
  - ports `i_clk`, `i_reset`, output `o_phase`.
  - instantiated only under `OUTPUT_BLINK_EN`.

## Test plan
- Reset then read all channels (NUM_CH=8) -> each `o_rdata=0`; `o_chan` all zero. A read at 0x1000_9000 -> `o_hit=0`, `o_rdata=0`.
- Write 0xDEADBEEF bmask 4'b1111 to 0x1000_2000, then 0x0000_00AA bmask 4'b0001 -> channel 2 reads 0xDEADBEAA. A write to 0x1000_9000 changes no channel.
- Channel 0 = 0x0000_00F0:
  - SET 0x0F at 0x1000_0004 -> 0xFF.
  - CLR 0x3C at 0x1000_0008 -> 0xC3.
  - TGL 0xFF at 0x1000_000C -> 0x3C.
- Same-cycle write 0x1 and read of channel 1 holding 0x5 -> `o_rdata=0x5`. A read the next cycle -> 0x1.
- `OUTPUT_BLINK_EN`, BLINK_DIV=4, ch3=0xFF, blink mask ch3 (0x1000_3010)=0x0F:
  - `o_chan[3]` alternates 0xFF/0xF0 every 4 clocks.
  - a readback of ch3 returns 0xFF.
- Assert `i_reset` for 1 cycle mid-phase -> all channels are `RST_VAL` immediately and phase=0; the first toggle comes exactly BLINK_DIV clocks after release.
